// File: rtl/sa_instr_sequencer.sv
// sa_instr_sequencer
// Instruction sequencer for the systolic-array datapath. Decodes one
// instruction per accept into single-cycle buffer/accumulator strobes, or into
// a multi-beat stream burst (auto-incrementing read address) followed by a
// drain window that lets the array flush.
//
// Handshake: an instruction is consumed on a rising clk edge where
// instr_valid && instr_ready. instr_ready is registered and is high only while
// the FSM is in IDLE. instr is ignored on any edge without an accept.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   instr_valid, instr         instruction in: opcode [MSB-:5], then address,
//                              data, len fields packed downward
//   instr_ready                sequencer can accept
//   inp_buf_* / wt_buf_*       input / weight buffer write (we, addr, data)
//   stream_inp_en/stream_wt_en streaming beat for inputs / weights
//   stream_addr                buffer read address of the current beat
//   acc_result_to_op_buf, acc_to_op_buf_addr   accumulator -> output buffer
//   op_buffer_instr_for_sending_data, out_buf_addr  output-buffer transmit
//   instr_for_accum_to_reset   accumulator reset
//   state_signal               01 write-type strobe, 10 streaming, 00 none
//   err_opcode                 one-cycle pulse on an unknown opcode
module sa_instr_sequencer #(
    parameter int INSTR_W    = 64,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int OPB_ADDR_W = 4,
    parameter int LEN_W      = 8,
    parameter int DRAIN_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    output logic                  inp_buf_we,
    output logic [ADDR_W-1:0]     inp_buf_addr,
    output logic [DATA_W-1:0]     inp_buf_data,
    output logic                  wt_buf_we,
    output logic [ADDR_W-1:0]     wt_buf_addr,
    output logic [DATA_W-1:0]     wt_buf_data,
    output logic                  stream_inp_en,
    output logic                  stream_wt_en,
    output logic [ADDR_W-1:0]     stream_addr,
    output logic                  acc_result_to_op_buf,
    output logic [OPB_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                  op_buffer_instr_for_sending_data,
    output logic [OPB_ADDR_W-1:0] out_buf_addr,
    output logic                  instr_for_accum_to_reset,
    output logic [1:0]            state_signal,
    output logic                  err_opcode
);

    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST =
        (DRAIN_CYC > 0) ? DCNT_W'(DRAIN_CYC - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;

    // Instruction fields, packed downward from the MSB.
    logic [4:0]        opc;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic [LEN_W-1:0]  f_len;
    logic              unused_instr;

    assign opc          = instr[INSTR_W-1 -: 5];
    assign f_addr       = instr[INSTR_W-6 -: ADDR_W];
    assign f_data       = instr[INSTR_W-6-ADDR_W -: DATA_W];
    assign f_len        = instr[INSTR_W-6-ADDR_W-DATA_W -: LEN_W];
    assign unused_instr = ^instr;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;     // index of the beat currently on the outputs
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                sel_wt_q, sel_wt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

    logic                  ready_q, ready_d;
    logic                  inp_we_q, inp_we_d;
    logic [ADDR_W-1:0]     inp_addr_q, inp_addr_d;
    logic [DATA_W-1:0]     inp_data_q, inp_data_d;
    logic                  wt_we_q, wt_we_d;
    logic [ADDR_W-1:0]     wt_addr_q, wt_addr_d;
    logic [DATA_W-1:0]     wt_data_q, wt_data_d;
    logic                  s_inp_q, s_inp_d;
    logic                  s_wt_q, s_wt_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic                  acc_q, acc_d;
    logic [OPB_ADDR_W-1:0] acc_addr_q, acc_addr_d;
    logic                  opb_q, opb_d;
    logic [OPB_ADDR_W-1:0] opb_addr_q, opb_addr_d;
    logic                  acc_rst_q, acc_rst_d;
    logic [1:0]            st_sig_q, st_sig_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign accept = instr_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        sel_wt_d   = sel_wt_q;
        dcnt_d     = dcnt_q;
        inp_we_d   = 1'b0;
        inp_addr_d = '0;
        inp_data_d = '0;
        wt_we_d    = 1'b0;
        wt_addr_d  = '0;
        wt_data_d  = '0;
        s_inp_d    = 1'b0;
        s_wt_d     = 1'b0;
        s_addr_d   = '0;
        acc_d      = 1'b0;
        acc_addr_d = '0;
        opb_d      = 1'b0;
        opb_addr_d = '0;
        acc_rst_d  = 1'b0;
        st_sig_d   = 2'b00;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opc)
                        5'b00000, 5'b11111: ;
                        5'b00001, 5'b00010: begin
                            // Beat 0 is launched straight from the accept edge.
                            state_d  = S_STREAM;
                            cnt_d    = '0;
                            len_d    = f_len;
                            base_d   = f_addr;
                            sel_wt_d = (opc == 5'b00010);
                            s_inp_d  = (opc == 5'b00001);
                            s_wt_d   = (opc == 5'b00010);
                            s_addr_d = f_addr;
                            st_sig_d = 2'b10;
                        end
                        5'b00011: begin
                            acc_d      = 1'b1;
                            acc_addr_d = f_addr[OPB_ADDR_W-1:0];
                            st_sig_d   = 2'b01;
                        end
                        5'b00100: begin
                            inp_we_d   = 1'b1;
                            inp_addr_d = f_addr;
                            inp_data_d = f_data;
                            st_sig_d   = 2'b01;
                        end
                        5'b00101: begin
                            wt_we_d   = 1'b1;
                            wt_addr_d = f_addr;
                            wt_data_d = f_data;
                            st_sig_d  = 2'b01;
                        end
                        5'b00110: begin
                            opb_d      = 1'b1;
                            opb_addr_d = f_addr[OPB_ADDR_W-1:0];
                            st_sig_d   = 2'b01;
                        end
                        5'b00111: begin
                            acc_rst_d = 1'b1;
                            st_sig_d  = 2'b01;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_STREAM: begin
                if (cnt_q == len_q) begin
                    dcnt_d  = '0;
                    state_d = (DRAIN_CYC == 0) ? S_IDLE : S_DRAIN;
                end else begin
                    cnt_d    = cnt_q + LEN_W'(1);
                    s_inp_d  = !sel_wt_q;
                    s_wt_d   = sel_wt_q;
                    // Wraps modulo 2^ADDR_W by truncation.
                    s_addr_d = base_q + ADDR_W'(cnt_d);
                    st_sig_d = 2'b10;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            sel_wt_q   <= 1'b0;
            dcnt_q     <= '0;
            ready_q    <= 1'b0;
            inp_we_q   <= 1'b0;
            inp_addr_q <= '0;
            inp_data_q <= '0;
            wt_we_q    <= 1'b0;
            wt_addr_q  <= '0;
            wt_data_q  <= '0;
            s_inp_q    <= 1'b0;
            s_wt_q     <= 1'b0;
            s_addr_q   <= '0;
            acc_q      <= 1'b0;
            acc_addr_q <= '0;
            opb_q      <= 1'b0;
            opb_addr_q <= '0;
            acc_rst_q  <= 1'b0;
            st_sig_q   <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            sel_wt_q   <= sel_wt_d;
            dcnt_q     <= dcnt_d;
            ready_q    <= ready_d;
            inp_we_q   <= inp_we_d;
            inp_addr_q <= inp_addr_d;
            inp_data_q <= inp_data_d;
            wt_we_q    <= wt_we_d;
            wt_addr_q  <= wt_addr_d;
            wt_data_q  <= wt_data_d;
            s_inp_q    <= s_inp_d;
            s_wt_q     <= s_wt_d;
            s_addr_q   <= s_addr_d;
            acc_q      <= acc_d;
            acc_addr_q <= acc_addr_d;
            opb_q      <= opb_d;
            opb_addr_q <= opb_addr_d;
            acc_rst_q  <= acc_rst_d;
            st_sig_q   <= st_sig_d;
            err_q      <= err_d;
        end
    end

    assign instr_ready                      = ready_q;
    assign inp_buf_we                       = inp_we_q;
    assign inp_buf_addr                     = inp_addr_q;
    assign inp_buf_data                     = inp_data_q;
    assign wt_buf_we                        = wt_we_q;
    assign wt_buf_addr                      = wt_addr_q;
    assign wt_buf_data                      = wt_data_q;
    assign stream_inp_en                    = s_inp_q;
    assign stream_wt_en                     = s_wt_q;
    assign stream_addr                      = s_addr_q;
    assign acc_result_to_op_buf             = acc_q;
    assign acc_to_op_buf_addr               = acc_addr_q;
    assign op_buffer_instr_for_sending_data = opb_q;
    assign out_buf_addr                     = opb_addr_q;
    assign instr_for_accum_to_reset         = acc_rst_q;
    assign state_signal                     = st_sig_q;
    assign err_opcode                       = err_q;

endmodule
